nonce_dispatcher: RTL and testbench

Scheduler that feeds one block-header work item at a time to LANES parallel SHA-256 solver lanes. It partitions the 32-bit nonce space evenly across the lanes, releases them together, and watches their status codes. It reports the first winning nonce, or exhaustion, to the host over a valid/ready result channel. It sits between the host work queue and the solver array, and is the only block that drives solver resets and nonce bases.

---
 rtl/nonce_dispatcher.sv | 141 ++++++++++++++
 tb/tb_nonce_dispatcher.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_dispatcher.sv
// Splits the 32-bit nonce space across LANES solver lanes and reports the first winning nonce or exhaustion.
// Optional RUN-state watchdog: define DISPATCH_TIMEOUT_EN to end RUN after TIMEOUT_CYCLES cycles.
module nonce_dispatcher #(
  parameter int          LANES          = 4,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd100_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  work_valid,
  output logic                  work_ready,
  input  logic [255:0]          work_midstate,
  input  logic [255:0]          work_target,
  input  logic [95:0]           work_leftovers,
  output logic [255:0]          solver_midstate,
  output logic [255:0]          solver_target,
  output logic [95:0]           solver_leftovers,
  output logic [LANES-1:0]      lane_rst_n,
  output logic [32*LANES-1:0]   lane_nonce_base,
  output logic [32*LANES-1:0]   lane_nonce_last,
  input  logic [3*LANES-1:0]    lane_state,
  input  logic [32*LANES-1:0]   lane_nonce,
  input  logic                  abort,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  res_found,
  output logic [31:0]           res_nonce,
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_RUN    = 2'd2,
    ST_REPORT = 2'd3
  } state_t;

  localparam logic [32:0] SPAN = 33'h1_0000_0000 >> $clog2(LANES);

  state_t      state, state_next;
  logic        any_found;
  logic        all_exhausted;
  logic        timeout;
  logic [31:0] win_nonce;

  // Nonce ranges are elaboration constants; with one lane the low 32 bits of SPAN are 0, so last wraps to all ones.
  for (genvar i = 0; i < LANES; i++) begin : g_range
    localparam logic [31:0] BASE = 32'(SPAN * 33'(i));
    localparam logic [31:0] SPAN_M1 = 32'(SPAN - 33'd1);
    assign lane_nonce_base[32*i +: 32] = BASE;
    assign lane_nonce_last[32*i +: 32] = BASE + SPAN_M1;
  end

`ifdef DISPATCH_TIMEOUT_EN
  logic [31:0] run_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt <= '0;
    end else if (state == ST_RUN) begin
      run_cnt <= run_cnt + 32'd1;
    end else begin
      run_cnt <= '0;
    end
  end

  // run_cnt holds the number of completed RUN cycles, so this fires in RUN cycle TIMEOUT_CYCLES.
  assign timeout = (run_cnt == TIMEOUT_CYCLES - 32'd1);
`else
  assign timeout = 1'b0;
`endif

  // Scan high-to-low so the lowest-index finder overwrites the others.
  always_comb begin
    any_found     = 1'b0;
    all_exhausted = 1'b1;
    win_nonce     = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (lane_state[3*i +: 3] == 3'd2) begin
        any_found = 1'b1;
        win_nonce = lane_nonce[32*i +: 32];
      end
      if (lane_state[3*i +: 3] != 3'd3) begin
        all_exhausted = 1'b0;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (work_valid) state_next = ST_LOAD;
      ST_LOAD:   state_next = ST_RUN;
      ST_RUN: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (any_found || all_exhausted || timeout) begin
          state_next = ST_REPORT;
        end
      end
      ST_REPORT: if (res_ready) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Registered outputs derive from the next state so they change on the same edge as the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_rst_n       <= '0;
      res_valid        <= 1'b0;
      res_found        <= 1'b0;
      res_nonce        <= '0;
      solver_midstate  <= '0;
      solver_target    <= '0;
      solver_leftovers <= '0;
    end else begin
      lane_rst_n <= {LANES{state_next == ST_RUN}};
      res_valid  <= (state_next == ST_REPORT);
      if (state == ST_RUN && state_next == ST_REPORT) begin
        res_found <= any_found;
        res_nonce <= any_found ? win_nonce : 32'hFFFF_FFFF;
      end
      if (state == ST_IDLE && work_valid) begin
        solver_midstate  <= work_midstate;
        solver_target    <= work_target;
        solver_leftovers <= work_leftovers;
      end
    end
  end

  assign work_ready = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_nonce_dispatcher.sv
// Randomized scoreboard bench for nonce_dispatcher with LANES=4 behavioural lanes.
module tb_nonce_dispatcher;
  localparam int L   = 4;
  localparam int INF = 1 << 30;
`ifdef DISPATCH_TIMEOUT_EN
  localparam int TO  = 50;
`endif

  typedef struct packed {
    logic        found;
    logic [31:0] nonce;
  } res_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            work_valid = 1'b0;
  logic            work_ready;
  logic [255:0]    work_midstate = '0;
  logic [255:0]    work_target = '0;
  logic [95:0]     work_leftovers = '0;
  logic [255:0]    solver_midstate;
  logic [255:0]    solver_target;
  logic [95:0]     solver_leftovers;
  logic [L-1:0]    lane_rst_n;
  logic [32*L-1:0] lane_nonce_base;
  logic [32*L-1:0] lane_nonce_last;
  logic [3*L-1:0]  lane_state = '0;
  logic [32*L-1:0] lane_nonce = '0;
  logic            abort = 1'b0;
  logic            res_valid;
  logic            res_ready = 1'b0;
  logic            res_found;
  logic [31:0]     res_nonce;
  logic            busy;

  nonce_dispatcher #(
    .LANES(L)
`ifdef DISPATCH_TIMEOUT_EN
    , .TIMEOUT_CYCLES(32'(TO))
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .work_valid(work_valid), .work_ready(work_ready),
    .work_midstate(work_midstate), .work_target(work_target), .work_leftovers(work_leftovers),
    .solver_midstate(solver_midstate), .solver_target(solver_target), .solver_leftovers(solver_leftovers),
    .lane_rst_n(lane_rst_n), .lane_nonce_base(lane_nonce_base), .lane_nonce_last(lane_nonce_last),
    .lane_state(lane_state), .lane_nonce(lane_nonce), .abort(abort),
    .res_valid(res_valid), .res_ready(res_ready), .res_found(res_found), .res_nonce(res_nonce),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   passes = 0;
  res_t exp_q[$];

  // Per-lane scenario: lane i finishes at RUN cycle sc_t[i], as found (sc_f) or exhausted.
  int          sc_t[L];
  bit          sc_f[L];
  logic [31:0] sc_n[L];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] base_of(input int i);
    return 32'(i) << 30;
  endfunction

  // Scoreboard monitor: pops on every accepted result and checks stability under backpressure.
  initial begin
    res_t held;
    bit   holding;
    holding = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      if (rst_n && res_valid) begin
        if (holding) begin
          chk("res_stable", {31'd0, res_found, res_nonce}, {31'd0, held.found, held.nonce});
        end
        if (res_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_result", 64'd1, 64'd0);
          end else begin
            res_t e;
            e = exp_q.pop_front();
            chk("res_found", {63'd0, res_found}, {63'd0, e.found});
            chk("res_nonce", {32'd0, res_nonce}, {32'd0, e.nonce});
          end
          holding = 1'b0;
        end else begin
          holding = 1'b1;
          held    = '{found: res_found, nonce: res_nonce};
        end
      end else begin
        holding = 1'b0;
      end
    end
  end

  // Drives a work item from #1 after an edge; returns #1 after the edge where lanes leave reset.
  task automatic start_work(input logic [255:0] mid, input logic [255:0] tgt, input logic [95:0] lft);
    int n;
    work_midstate  = mid;
    work_target    = tgt;
    work_leftovers = lft;
    work_valid     = 1'b1;
    n = 0;
    while (!work_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) chk("work_ready_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    work_valid = 1'b0;
    chk("load_busy", {62'd0, busy, work_ready}, {62'd0, 1'b1, 1'b0});
    chk("load_lane_rst", {60'd0, lane_rst_n}, 64'd0);
    chk("solver_midstate", solver_midstate[63:0], mid[63:0]);
    chk("solver_target", solver_target[255:192], tgt[255:192]);
    chk("solver_leftovers", solver_leftovers[63:0], lft[63:0]);
    @(posedge clk); #1;
    chk("run_lane_rst", {60'd0, lane_rst_n}, {60'd0, {L{1'b1}}});
  endtask

  task automatic run_item(input int abort_k, input int bp,
                          input logic [255:0] mid, input logic [255:0] tgt, input logic [95:0] lft);
    int   tf, lim, end_k, win, k;
    bit   anyf, aborted, ended;
    res_t e;
    // Reference: earliest found wins (lowest index on ties); otherwise the last exhausting lane ends RUN.
    tf = INF; lim = 0; anyf = 1'b0; win = 0;
    for (int i = L - 1; i >= 0; i--) begin
      if (sc_f[i]) begin
        anyf = 1'b1;
        if (sc_t[i] <= tf) begin tf = sc_t[i]; win = i; end
      end
      if (sc_t[i] > lim) lim = sc_t[i];
    end
    if (anyf) lim = INF;
`ifdef DISPATCH_TIMEOUT_EN
    if (TO < lim) lim = TO;
`endif
    if (tf <= lim) begin
      end_k = tf;
      e = '{found: 1'b1, nonce: sc_n[win]};
    end else begin
      end_k = lim;
      e = '{found: 1'b0, nonce: 32'hFFFF_FFFF};
    end
    aborted = (abort_k > 0) && (abort_k <= end_k);
    if (!aborted) exp_q.push_back(e);

    start_work(mid, tgt, lft);
    ended = 1'b0;
    for (k = 1; k < 300 && !ended; k++) begin
      for (int i = 0; i < L; i++) begin
        if (k >= sc_t[i]) begin
          lane_state[3*i +: 3] = sc_f[i] ? 3'd2 : 3'd3;
          lane_nonce[32*i +: 32] = sc_f[i] ? sc_n[i] : base_of(i) + 32'h3FFF_FFFF;
        end else begin
          int c;
          c = $urandom_range(0, 5);
          lane_state[3*i +: 3] = (c < 2) ? 3'(c) : 3'(c + 2);
          lane_nonce[32*i +: 32] = base_of(i) + 32'(k);
        end
      end
      abort = (k == abort_k);
      @(posedge clk); #1;
      abort = 1'b0;
      if (aborted && k == abort_k) begin
        ended = 1'b1;
        chk("abort_idle", {61'd0, busy, work_ready, res_valid}, {61'd0, 1'b0, 1'b1, 1'b0});
        chk("abort_lane_rst", {60'd0, lane_rst_n}, 64'd0);
      end else if (!aborted && k == end_k) begin
        ended = 1'b1;
        chk("report_valid", {62'd0, res_valid, busy}, {62'd0, 1'b1, 1'b1});
        chk("report_lane_rst", {60'd0, lane_rst_n}, 64'd0);
      end else begin
        chk("run_no_result", {63'd0, res_valid}, 64'd0);
      end
    end
    if (!ended) chk("run_end_timeout", 64'd0, 64'd1);
    lane_state = '0;
    lane_nonce = '0;
    if (!aborted && ended) begin
      for (int j = 0; j < bp; j++) begin
        chk("bp_hold", {60'd0, lane_rst_n, work_ready, res_valid}, {60'd0, {L{1'b0}}, 1'b0, 1'b1});
        @(posedge clk); #1;
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      chk("post_accept", {62'd0, work_ready, res_valid}, {62'd0, 1'b1, 1'b0});
    end
  endtask

  task automatic set_lane(input int i, input bit f, input int t, input logic [31:0] n);
    sc_f[i] = f; sc_t[i] = t; sc_n[i] = n;
  endtask

  initial begin
    logic [255:0] km, kt;
    logic [95:0]  kl;
    km = {32'h4a03aeb2, 192'h0123456789abcdef_fedcba9876543210_0f1e2d3c4b5a6978, 32'h00ef7254};
    kt = {88'h00000000000000000440C4, 168'h0};
    kl = 96'h15274c646c51f957c4400418;

    #3;
    chk("rst_ready_busy", {62'd0, work_ready, busy}, {62'd0, 1'b1, 1'b0});
    chk("rst_res", {31'd0, res_valid, res_found, res_nonce}, 64'd0);
    chk("rst_lane_rst", {60'd0, lane_rst_n}, 64'd0);
    chk("rst_solver", {63'd0, |{solver_midstate, solver_target, solver_leftovers}}, 64'd0);
    chk("base1", {32'd0, lane_nonce_base[63:32]}, 64'h4000_0000);
    chk("base2", {32'd0, lane_nonce_base[95:64]}, 64'h8000_0000);
    chk("last0", {32'd0, lane_nonce_last[31:0]}, 64'h3FFF_FFFF);
    chk("last3", {32'd0, lane_nonce_last[127:96]}, 64'hFFFF_FFFF);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Known solution: lane 2 finds while others keep searching.
    for (int i = 0; i < L; i++) set_lane(i, 1'b0, INF, '0);
    set_lane(2, 1'b1, 7, 32'h9c9a4fc0);
    run_item(0, 0, km, kt, kl);

    // Exhaustion with lane 3 finishing last.
    set_lane(0, 1'b0, 3, '0); set_lane(1, 1'b0, 5, '0);
    set_lane(2, 1'b0, 6, '0); set_lane(3, 1'b0, 11, '0);
    run_item(0, 1, ~km, ~kt, ~kl);

    // Tie: lanes 1 and 3 find together while 0 and 2 exhaust the same cycle.
    set_lane(0, 1'b0, 6, '0); set_lane(1, 1'b1, 6, 32'h4000_0010);
    set_lane(2, 1'b0, 6, '0); set_lane(3, 1'b1, 6, 32'hC000_0020);
    run_item(0, 0, km ^ 256'd1, kt, kl);

    // Abort at RUN cycle 10 on a same-cycle find, then immediate new work with a 20-cycle backpressure.
    for (int i = 0; i < L; i++) set_lane(i, 1'b0, INF, '0);
    set_lane(0, 1'b1, 10, 32'h0000_1234);
    run_item(10, 0, km, kt, kl);
    set_lane(0, 1'b0, 4, '0); set_lane(1, 1'b1, 9, 32'h5555_0001);
    set_lane(2, 1'b0, INF, '0); set_lane(3, 1'b1, 9, 32'hD000_0000);
    run_item(0, 20, kt, km, kl);

`ifdef DISPATCH_TIMEOUT_EN
    for (int i = 0; i < L; i++) set_lane(i, 1'b0, INF, '0);
    run_item(0, 0, km, kt, kl);
    set_lane(2, 1'b1, TO, 32'h8000_0050);
    run_item(0, 0, km, kt, kl);
`endif

    for (int n = 0; n < 25; n++) begin
      int ak;
      for (int i = 0; i < L; i++) begin
        set_lane(i, ($urandom_range(0, 3) == 0), $urandom_range(1, 30),
                 base_of(i) + 32'($urandom_range(0, 32'h3FFF_FFFF)));
      end
      ak = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 30) : 0;
      run_item(ak, $urandom_range(0, 3), {8{$urandom}}, {8{$urandom}}, {3{$urandom}});
    end

    // Asynchronous reset mid-RUN discards the work at once.
    for (int i = 0; i < L; i++) set_lane(i, 1'b0, INF, '0);
    start_work(km, kt, kl);
    lane_state = {L{3'd1}};
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", {62'd0, work_ready, busy}, {62'd0, 1'b1, 1'b0});
    chk("arst_lane_rst", {60'd0, lane_rst_n}, 64'd0);
    chk("arst_res", {31'd0, res_valid, res_found, res_nonce}, 64'd0);
    chk("arst_solver", {63'd0, |{solver_midstate, solver_target, solver_leftovers}}, 64'd0);
    lane_state = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passes, checks);
    $fatal(1, "watchdog");
  end

endmodule
